// File: rtl/ecc_sed_encoder_par.sv
// ecc_sed_encoder_par: interleaved single-error-detect parity encoder with 2-entry output FIFO and one-shot error injection
module ecc_sed_encoder_par #(
  parameter int DATA_W = 12,
  parameter int GROUPS = 1,
  parameter int ODD_PARITY = 0,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     data_valid,
  output logic                     data_ready,
  input  logic [DATA_W-1:0]        data,
  input  logic                     inj_err,
  output logic                     enc_valid,
  input  logic                     enc_ready,
  output logic [DATA_W+GROUPS-1:0] enc_codeword,
  output logic [CNT_W-1:0]         word_count,
  output logic                     inj_pending
);
  localparam int W = DATA_W + GROUPS;
  if (GROUPS < 1 || GROUPS > DATA_W) begin : g_bad_groups
    $error("GROUPS must be in 1..DATA_W");
  end
  logic [W-1:0] mem [2];
  logic rd, wr, acc, hs, flip;
  logic [1:0] cnt;
  logic [GROUPS-1:0] par;
  // group parity of the incoming word, with optional one-shot corruption of parity[0]
  always_comb begin
    par = '0;
    for (int i = 0; i < DATA_W; i++) par[i % GROUPS] = par[i % GROUPS] ^ data[i];
    flip = acc && (inj_pending || inj_err);
    par = par ^ {GROUPS{ODD_PARITY != 0}} ^ GROUPS'(flip);
  end
  assign data_ready   = !rst && cnt != 2'd2;
  assign enc_valid    = cnt != 2'd0;
  assign acc          = data_valid && data_ready;
  assign hs           = enc_valid && enc_ready;
  assign enc_codeword = mem[rd];
  // FIFO storage, pointers, occupancy, delivered counter and injection arm
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0]      <= '0;
      mem[1]      <= '0;
      rd          <= 1'b0;
      wr          <= 1'b0;
      cnt         <= 2'd0;
      word_count  <= '0;
      inj_pending <= 1'b0;
    end else begin
      if (acc) begin
        mem[wr] <= {par, data};
        wr      <= ~wr;
      end
      if (hs) begin
        rd         <= ~rd;
        word_count <= word_count + 1'b1;
      end
      cnt         <= cnt + 2'(acc) - 2'(hs);
      inj_pending <= !acc && (inj_pending || inj_err);
    end
  end
endmodule

// File: tb/tb_ecc_sed_encoder_par.sv
// tb_ecc_sed_encoder_par: four parameterisations driven in lockstep and checked against a queue model
module tb_ecc_sed_encoder_par;
  logic clk = 0, rst = 1, data_valid = 0, inj_err = 0, enc_ready = 0;
  logic [11:0] data = 0;
  logic r0, r1, r2, r3, v0, v1, v2, v3, p0, p1, p2, p3;
  logic [12:0] c0, c1;
  logic [13:0] c2;
  logic [14:0] c3;
  logic [15:0] w0, w1, w2;
  logic [1:0] w3;
  int checks = 0, errors = 0;
  logic [11:0] q_d[$];
  bit q_i[$];
  int delivered = 0, n;
  bit pend = 0, started = 0, m_hs, m_ac;

  always #5 clk = ~clk;

  ecc_sed_encoder_par #(.DATA_W(12), .GROUPS(1), .ODD_PARITY(0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data_ready(r0), .data(data), .inj_err(inj_err),
    .enc_valid(v0), .enc_ready(enc_ready), .enc_codeword(c0), .word_count(w0), .inj_pending(p0));
  ecc_sed_encoder_par #(.DATA_W(12), .GROUPS(1), .ODD_PARITY(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data_ready(r1), .data(data), .inj_err(inj_err),
    .enc_valid(v1), .enc_ready(enc_ready), .enc_codeword(c1), .word_count(w1), .inj_pending(p1));
  ecc_sed_encoder_par #(.DATA_W(12), .GROUPS(2), .ODD_PARITY(0), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data_ready(r2), .data(data), .inj_err(inj_err),
    .enc_valid(v2), .enc_ready(enc_ready), .enc_codeword(c2), .word_count(w2), .inj_pending(p2));
  ecc_sed_encoder_par #(.DATA_W(12), .GROUPS(3), .ODD_PARITY(0), .CNT_W(2)) u3 (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data_ready(r3), .data(data), .inj_err(inj_err),
    .enc_valid(v3), .enc_ready(enc_ready), .enc_codeword(c3), .word_count(w3), .inj_pending(p3));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] cw(input logic [11:0] d, input int g, input bit odd, input bit inj);
    logic [31:0] r;
    int ones;
    r = {20'b0, d};
    for (int k = 0; k < g; k++) begin
      ones = 0;
      for (int i = k; i < 12; i += g) ones += int'(d[i]);
      r[12+k] = ((ones % 2) == 1) ^ odd ^ (k == 0 && inj);
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q_d.delete();
      q_i.delete();
      delivered = 0;
      pend = 0;
      started = 1;
    end else begin
      m_hs = enc_ready && q_d.size() > 0;
      m_ac = data_valid && q_d.size() < 2;
      if (m_hs) begin
        void'(q_d.pop_front());
        void'(q_i.pop_front());
        delivered++;
      end
      if (m_ac) begin
        q_d.push_back(data);
        q_i.push_back(pend || inj_err);
      end
      pend = m_ac ? 1'b0 : (pend || inj_err);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      n = q_d.size();
      chk("valid0", 32'(v0), 32'(n > 0));
      chk("valid1", 32'(v1), 32'(n > 0));
      chk("valid2", 32'(v2), 32'(n > 0));
      chk("valid3", 32'(v3), 32'(n > 0));
      chk("ready0", 32'(r0), 32'(!rst && n < 2));
      chk("ready3", 32'(r3), 32'(!rst && n < 2));
      chk("count0", 32'(w0), delivered % 65536);
      chk("count1", 32'(w1), delivered % 65536);
      chk("count2", 32'(w2), delivered % 65536);
      chk("count3", 32'(w3), delivered % 4);
      chk("pend0", 32'(p0), 32'(pend));
      chk("pend3", 32'(p3), 32'(pend));
      if (n > 0) begin
        chk("cw0", 32'(c0), cw(q_d[0], 1, 0, q_i[0]));
        chk("cw1", 32'(c1), cw(q_d[0], 1, 1, q_i[0]));
        chk("cw2", 32'(c2), cw(q_d[0], 2, 0, q_i[0]));
        chk("cw3", 32'(c3), cw(q_d[0], 3, 0, q_i[0]));
      end
    end
  end

  task automatic cyc(input logic v, input logic [11:0] d, input logic r, input logic inj, input logic rs = 0);
    #1;
    data_valid = v;
    data = d;
    enc_ready = r;
    inj_err = inj;
    rst = rs;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("lit_rst_cw", 32'(c0), 0);
    chk("lit_rst_ready", 32'(r0), 0);
    chk("lit_rst_pend", 32'(p0), 0);
    cyc(1, 12'h001, 0, 0);
    chk("lit_001_g1", 32'(c0), 32'h1001);
    chk("lit_001_g2", 32'(c2), 32'h1001);
    chk("lit_latency", 32'(v0), 1);
    cyc(0, 0, 1, 0);
    chk("lit_wc1", 32'(w0), 1);
    cyc(1, 12'hFFF, 0, 0);
    chk("lit_fff_even", 32'(c0), 32'h0FFF);
    chk("lit_fff_odd", 32'(c1), 32'h1FFF);
    cyc(0, 0, 1, 0);
    cyc(1, 12'h002, 0, 0);
    chk("lit_002_g2", 32'(c2), 32'h2002);
    cyc(0, 0, 1, 0);
    cyc(1, 12'h003, 0, 0);
    chk("lit_003_g2", 32'(c2), 32'h3003);
    chk("lit_003_g3", 32'(c3), 32'h3003);
    cyc(0, 0, 1, 0);
    cyc(1, 12'h0AA, 0, 0);
    cyc(1, 12'h055, 0, 0);
    chk("lit_full_ready", 32'(r0), 0);
    cyc(1, 12'h123, 0, 0);
    chk("lit_hold_cw", 32'(c0), 32'h00AA);
    cyc(0, 0, 1, 0);
    chk("lit_b_cw", 32'(c0), 32'h0055);
    chk("lit_b_ready", 32'(r0), 1);
    cyc(0, 0, 1, 0);
    chk("lit_drained", 32'(v0), 0);
    cyc(0, 0, 0, 1);
    chk("lit_inj_pend", 32'(p0), 1);
    cyc(1, 12'h000, 0, 0);
    chk("lit_inj_cw", 32'(c0), 32'h1000);
    chk("lit_inj_clr", 32'(p0), 0);
    cyc(1, 12'h000, 1, 0);
    chk("lit_clean_cw", 32'(c0), 32'h0000);
    chk("lit_clean_valid", 32'(v0), 1);
    cyc(0, 0, 1, 0);
    cyc(1, 12'h001, 0, 1);
    chk("lit_inj_same", 32'(c0), 32'h0001);
    chk("lit_inj_same_p", 32'(p0), 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 12'h010, 0, 0);
    cyc(1, 12'h010, 0, 0);
    cyc(0, 0, 1, 0);
    chk("lit_one_shot", 32'(c0), 32'h1010);
    cyc(0, 0, 1, 0);
    cyc(1, 12'h111, 0, 0);
    cyc(1, 12'h222, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("lit_mid_rst_v", 32'(v0), 0);
    chk("lit_mid_rst_wc", 32'(w0), 0);
    chk("lit_mid_rst_p", 32'(p0), 0);
    cyc(1, 12'h001, 0, 0);
    chk("lit_post_rst", 32'(c0), 32'h1001);
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 12'(i * 37 + 5), 1, 0);
    cyc(0, 0, 1, 0);
    chk("lit_wrap_c2", 32'(w3), 1);
    chk("lit_wrap_c16", 32'(w0), 5);
    for (int i = 0; i < 200; i++)
      cyc(1'($urandom_range(0, 1)), 12'($urandom), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 60) == 0));
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
